// File: rtl/cnn_pkg.sv
// Shared constants and types for the conv2 window path: window geometry,
// the tap-index helper that fixes weight-file ordering, the default pixel
// type and the debug snapshot exported by the window buffer.
package cnn_pkg;

  localparam int FILTER_SIZE = 5;
  localparam int TAPS        = FILTER_SIZE * FILTER_SIZE;
  localparam int PIXEL_BITS  = 12;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  // Raster position of the pixel being accepted and whether it completes a window.
  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       win_valid;
  } conv2_dbg_t;

  // Tap k = r*FILTER_SIZE + c; r=0 is the oldest (top) row, c=0 the oldest (left) column.
  function automatic int tap(input int r, input int c);
    return r * FILTER_SIZE + c;
  endfunction

endpackage

// File: rtl/conv2_window_buf_if.sv
// Pixel-in / window-out bundle of one conv2 window buffer.
// Optional macro: CONV2_BUF_FRAME_DONE_EN adds the frame_done pulse.
//
// Handshake: valid-only, no ready. data_in is consumed on every rising edge
// where valid_in is 1. valid_out_buf is a one-cycle strobe announcing that
// data_out carries a new window; the consumer must take every strobe, and
// data_out stays stable until the next strobe.
interface conv2_window_buf_if #(
  parameter int DATA_BITS = 12,
  parameter int TAPS      = 25
);

  logic                      valid_in;
  logic [DATA_BITS-1:0]      data_in;
  logic [TAPS*DATA_BITS-1:0] data_out;
  logic                      valid_out_buf;
`ifdef CONV2_BUF_FRAME_DONE_EN
  logic                      frame_done;
`endif

`ifdef CONV2_BUF_FRAME_DONE_EN
  // Pixel source / window consumer side.
  modport master (
    output valid_in, data_in,
    input  data_out, valid_out_buf, frame_done
  );

  // Window buffer side.
  modport slave (
    input  valid_in, data_in,
    output data_out, valid_out_buf, frame_done
  );
`else
  // Pixel source / window consumer side.
  modport master (
    output valid_in, data_in,
    input  data_out, valid_out_buf
  );

  // Window buffer side.
  modport slave (
    input  valid_in, data_in,
    output data_out, valid_out_buf
  );
`endif

endinterface

// File: rtl/conv2_line_fifo.sv
// One feature-map row of delay: a DEPTH-deep shift register that advances
// only on accepted pixels. dout_o is the pixel accepted DEPTH pixels ago,
// i.e. the same column one row up. Contents are not reset; the window
// buffer's row guard hides whatever is left over.
module conv2_line_fifo #(
  parameter int DEPTH     = 12,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic [DATA_BITS-1:0] din_i,
  output logic [DATA_BITS-1:0] dout_o
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // Shift one slot per accepted pixel; the oldest entry drops off the end.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv2_window_buf.sv
// conv2 window buffer: turns a raster-scan pixel stream from one pool1
// channel into a FILTER_SIZE x FILTER_SIZE sliding window (stride 1, no
// padding) with a one-cycle valid strobe.
// Optional macro: CONV2_BUF_FRAME_DONE_EN adds frame_done, a pulse on the
// strobe of the last window of each frame.
module conv2_window_buf
  import cnn_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int HEIGHT    = 12,
  parameter int DATA_BITS = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  conv2_window_buf_if.slave  bus,
  output conv2_dbg_t         dbg_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int NF = FILTER_SIZE - 1;   // number of line FIFOs
  localparam int OW = TAPS * DATA_BITS;

  typedef logic [DATA_BITS-1:0] pix_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  pix_t          win_q [FILTER_SIZE][FILTER_SIZE];
  pix_t          win_d [FILTER_SIZE][FILTER_SIZE];
  pix_t          fifo_in  [NF];
  pix_t          fifo_out [NF];
  pix_t          new_col  [FILTER_SIZE];
  logic [OW-1:0] data_out_q, data_out_d;
  logic          valid_out_q;
  logic          last_col, last_row;
  logic          win_valid;

  // Line FIFO chain: FIFO i delays by i+1 rows.
  for (genvar i = 0; i < NF; i++) begin : g_line
    conv2_line_fifo #(
      .DEPTH     (WIDTH),
      .DATA_BITS (DATA_BITS)
    ) u_fifo (
      .clk    (clk),
      .en_i   (bus.valid_in),
      .din_i  (fifo_in[i]),
      .dout_o (fifo_out[i])
    );
  end

  // Route the new pixel and FIFO outputs: bottom row gets the live pixel,
  // each row above gets the same column from one more row back.
  always_comb begin
    fifo_in[0]          = bus.data_in;
    new_col[NF]         = bus.data_in;
    for (int i = 1; i < NF; i++) begin
      fifo_in[i] = fifo_out[i-1];
    end
    for (int i = 0; i < NF; i++) begin
      new_col[NF-1-i] = fifo_out[i];
    end
  end

  // Raster counters, window shift and the next registered window image.
  always_comb begin
    last_col   = (col_q == CW'(WIDTH - 1));
    last_row   = (row_q == RW'(HEIGHT - 1));
    // Rows 0..NF-1 of a frame never complete a window, which also masks
    // stale line-FIFO contents left from the previous frame or a reset.
    win_valid  = bus.valid_in &&
                 (row_q >= RW'(FILTER_SIZE - 1)) &&
                 (col_q >= CW'(FILTER_SIZE - 1));
    col_d      = col_q;
    row_d      = row_q;
    win_d      = win_q;
    data_out_d = data_out_q;
    if (bus.valid_in) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < NF; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][NF] = new_col[r];
      end
    end
    if (win_valid) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE; c++) begin
          data_out_d[tap(r, c)*DATA_BITS +: DATA_BITS] = win_d[r][c];
        end
      end
    end
  end

  // Counter, window and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      data_out_q  <= data_out_d;
      valid_out_q <= win_valid;
      win_q       <= win_d;
    end
  end

`ifdef CONV2_BUF_FRAME_DONE_EN
  logic frame_done_q;

  // Pulse alongside the strobe of the frame's bottom-right window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= win_valid && last_col && last_row;
    end
  end

  assign bus.frame_done = frame_done_q;
`endif

  assign bus.data_out      = data_out_q;
  assign bus.valid_out_buf = valid_out_q;

  assign dbg_o.row       = 8'(row_q);
  assign dbg_o.col       = 8'(col_q);
  assign dbg_o.win_valid = win_valid;

endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf: a 12x12 instance for the main
// scenarios and a 5x5 instance for the single-window frame.
module tb_conv2_window_buf;
  import cnn_pkg::*;

  localparam int W = TAPS * 12;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv2_window_buf_if #(.DATA_BITS(12), .TAPS(TAPS)) bus  ();
  conv2_window_buf_if #(.DATA_BITS(12), .TAPS(TAPS)) bus5 ();
  conv2_dbg_t dbg, dbg5;

  conv2_window_buf #(.WIDTH(12), .HEIGHT(12), .DATA_BITS(12)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .dbg_o (dbg)
  );

  conv2_window_buf #(.WIDTH(5), .HEIGHT(5), .DATA_BITS(12)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5),
    .dbg_o (dbg5)
  );

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic        last_vin = 1'b0;
  logic [W-1:0] obs_q[$];
  logic [W-1:0] obs5_q[$];
  int          obs_cyc_q[$];
  int          strobe_cnt = 0;
  int          strobe5_cnt = 0;
  int          spurious = 0;
  int          unstable = 0;
  logic [W-1:0] prev_out = '0;
`ifdef CONV2_BUF_FRAME_DONE_EN
  int          fd_cnt = 0;
  int          fd_idx = -1;
  int          fd_bad = 0;
`endif

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_vin <= bus.valid_in;
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_out = '0;
    end else begin
      if (bus.valid_out_buf) begin
        obs_q.push_back(bus.data_out);
        obs_cyc_q.push_back(cyc);
        strobe_cnt++;
        if (!last_vin) spurious++;
      end else if (bus.data_out !== prev_out) begin
        unstable++;
      end
      prev_out = bus.data_out;
      if (bus5.valid_out_buf) begin
        obs5_q.push_back(bus5.data_out);
        strobe5_cnt++;
      end
`ifdef CONV2_BUF_FRAME_DONE_EN
      if (bus.frame_done) begin
        fd_cnt++;
        fd_idx = strobe_cnt - 1;
        if (!bus.valid_out_buf) fd_bad++;
      end
`endif
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int p52_cyc  = -1;

  // Expected window whose bottom-right pixel is (wr, wc) of a ramp frame.
  function automatic logic [W-1:0] exp_win(input int off, input int w, input int wr, input int wc);
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        v[(r*5 + c)*12 +: 12] = 12'(off + (wr - 4 + r)*w + (wc - 4 + c));
    return v;
  endfunction

  task automatic push_frame_exp(input int off);
    for (int wr = 4; wr < 12; wr++)
      for (int wc = 4; wc < 12; wc++)
        exp_q.push_back(exp_win(off, 12, wr, wc));
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [11:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive5(input logic v, input logic [11:0] d);
    bus5.valid_in = v;
    bus5.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_rows(input int off, input int r0, input int r1, input bit gaps);
    for (int r = r0; r <= r1; r++) begin
      for (int c = 0; c < 12; c++) begin
        if (gaps) begin
          int k = 0;
          while (k < 4 && $urandom_range(0, 1) == 1) begin
            drive(1'b0, 12'($urandom_range(0, 4095)));
            k++;
          end
        end
        drive(1'b1, 12'(off + r*12 + c));
        if (r == 4 && c == 4) p52_cyc = cyc;
      end
    end
  endtask

  task automatic apply_reset();
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus5.valid_in = 1'b0;
    bus5.data_in  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus5.valid_in = 1'b0;
    bus5.data_in  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data_out got=%h exp=0", bus.data_out); end
    n_checks++; if (bus.valid_out_buf !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out_buf); end
    n_checks++; if (bus5.data_out !== '0) begin n_fail++; $display("FAIL reset5_data_out got=%h exp=0", bus5.data_out); end
    n_checks++; if (dbg.row !== 8'd0 || dbg.col !== 8'd0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", dbg.row, dbg.col); end
`ifdef CONV2_BUF_FRAME_DONE_EN
    n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.valid_out_buf !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got=%b exp=0", bus.valid_out_buf); end
  endtask

  task automatic test_ramp();
    int base, s0, sp0, un0;
    logic [W-1:0] got, first, last;
`ifdef CONV2_BUF_FRAME_DONE_EN
    int fd0;
`endif
    apply_reset();
    exp_q.delete();
    base = obs_q.size(); s0 = strobe_cnt; sp0 = spurious; un0 = unstable;
`ifdef CONV2_BUF_FRAME_DONE_EN
    fd0 = fd_cnt;
`endif
    push_frame_exp(0);
    send_rows(0, 0, 11, 1'b0);
    repeat (3) drive(1'b0, 12'd0);
    n_checks++; if (strobe_cnt - s0 !== 64) begin n_fail++; $display("FAIL ramp_count got=%0d exp=64", strobe_cnt - s0); end
    n_checks++; if (obs_cyc_q.size() <= base || obs_cyc_q[base] !== p52_cyc) begin n_fail++; $display("FAIL ramp_latency got=%0d exp=%0d", (obs_cyc_q.size() > base) ? obs_cyc_q[base] : -1, p52_cyc); end
    first = (obs_q.size() > base) ? obs_q[base] : 'x;
    n_checks++; if (first[0*12 +: 12] !== 12'd0)   begin n_fail++; $display("FAIL ramp_tap0 got=%0d exp=0", first[0*12 +: 12]); end
    n_checks++; if (first[4*12 +: 12] !== 12'd4)   begin n_fail++; $display("FAIL ramp_tap4 got=%0d exp=4", first[4*12 +: 12]); end
    n_checks++; if (first[20*12 +: 12] !== 12'd48) begin n_fail++; $display("FAIL ramp_tap20 got=%0d exp=48", first[20*12 +: 12]); end
    n_checks++; if (first[24*12 +: 12] !== 12'd52) begin n_fail++; $display("FAIL ramp_tap24 got=%0d exp=52", first[24*12 +: 12]); end
    for (int i = 0; i < 64; i++) begin
      got = (obs_q.size() > base + i) ? obs_q[base + i] : 'x;
      n_checks++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL ramp_win%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    last = (obs_q.size() > base + 63) ? obs_q[base + 63] : 'x;
    n_checks++; if (last[0*12 +: 12] !== 12'd91)   begin n_fail++; $display("FAIL last_tap0 got=%0d exp=91", last[0*12 +: 12]); end
    n_checks++; if (last[24*12 +: 12] !== 12'd143) begin n_fail++; $display("FAIL last_tap24 got=%0d exp=143", last[24*12 +: 12]); end
    n_checks++; if (bus.data_out !== exp_q[63]) begin n_fail++; $display("FAIL ramp_hold got=%h exp=%h", bus.data_out, exp_q[63]); end
    n_checks++; if (dbg.row !== 8'd0 || dbg.col !== 8'd0) begin n_fail++; $display("FAIL ramp_wrap got=%0d/%0d exp=0/0", dbg.row, dbg.col); end
    n_checks++; if (spurious - sp0 !== 0) begin n_fail++; $display("FAIL ramp_spurious got=%0d exp=0", spurious - sp0); end
    n_checks++; if (unstable - un0 !== 0) begin n_fail++; $display("FAIL ramp_stable got=%0d exp=0", unstable - un0); end
`ifdef CONV2_BUF_FRAME_DONE_EN
    n_checks++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL fd_count got=%0d exp=1", fd_cnt - fd0); end
    n_checks++; if (fd_idx !== s0 + 63) begin n_fail++; $display("FAIL fd_index got=%0d exp=%0d", fd_idx, s0 + 63); end
    n_checks++; if (fd_bad !== 0) begin n_fail++; $display("FAIL fd_coincident got=%0d exp=0", fd_bad); end
`endif
  endtask

  task automatic test_gaps();
    int base, s0, sp0, un0;
    logic [W-1:0] got;
    apply_reset();
    exp_q.delete();
    base = obs_q.size(); s0 = strobe_cnt; sp0 = spurious; un0 = unstable;
    push_frame_exp(0);
    send_rows(0, 0, 11, 1'b1);
    repeat (3) drive(1'b0, 12'd0);
    n_checks++; if (strobe_cnt - s0 !== 64) begin n_fail++; $display("FAIL gaps_count got=%0d exp=64", strobe_cnt - s0); end
    for (int i = 0; i < 64; i++) begin
      got = (obs_q.size() > base + i) ? obs_q[base + i] : 'x;
      n_checks++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL gaps_win%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    n_checks++; if (spurious - sp0 !== 0) begin n_fail++; $display("FAIL gaps_spurious got=%0d exp=0", spurious - sp0); end
    n_checks++; if (unstable - un0 !== 0) begin n_fail++; $display("FAIL gaps_stable got=%0d exp=0", unstable - un0); end
  endtask

  task automatic test_back_to_back();
    int base, s0;
    logic [W-1:0] got, f2;
    apply_reset();
    exp_q.delete();
    base = obs_q.size(); s0 = strobe_cnt;
    push_frame_exp(0);
    push_frame_exp(100);
    send_rows(0, 0, 11, 1'b0);
    send_rows(100, 0, 3, 1'b0);
    n_checks++; if (strobe_cnt - s0 !== 64) begin n_fail++; $display("FAIL b2b_stale_rows got=%0d exp=64", strobe_cnt - s0); end
    send_rows(100, 4, 11, 1'b0);
    repeat (3) drive(1'b0, 12'd0);
    n_checks++; if (strobe_cnt - s0 !== 128) begin n_fail++; $display("FAIL b2b_count got=%0d exp=128", strobe_cnt - s0); end
    f2 = (obs_q.size() > base + 64) ? obs_q[base + 64] : 'x;
    n_checks++; if (f2[0*12 +: 12] !== 12'd100)  begin n_fail++; $display("FAIL b2b_tap0 got=%0d exp=100", f2[0*12 +: 12]); end
    n_checks++; if (f2[24*12 +: 12] !== 12'd152) begin n_fail++; $display("FAIL b2b_tap24 got=%0d exp=152", f2[24*12 +: 12]); end
    for (int i = 0; i < 128; i++) begin
      got = (obs_q.size() > base + i) ? obs_q[base + i] : 'x;
      n_checks++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL b2b_win%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int base, s0;
    logic [W-1:0] got;
    apply_reset();
    exp_q.delete();
    base = obs_q.size(); s0 = strobe_cnt;
    push_frame_exp(0);
    push_frame_exp(0);
    send_rows(0, 0, 11, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b1, 12'(i));
    bus.valid_in = 1'b0;
    n_checks++; if (bus.data_out !== exp_q[63]) begin n_fail++; $display("FAIL mid_pre_reset got=%h exp=%h", bus.data_out, exp_q[63]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL mid_async_data got=%h exp=0", bus.data_out); end
    n_checks++; if (bus.valid_out_buf !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got=%b exp=0", bus.valid_out_buf); end
    n_checks++; if (dbg.row !== 8'd0 || dbg.col !== 8'd0) begin n_fail++; $display("FAIL mid_async_counters got=%0d/%0d exp=0/0", dbg.row, dbg.col); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_rows(0, 0, 11, 1'b0);
    repeat (3) drive(1'b0, 12'd0);
    n_checks++; if (strobe_cnt - s0 !== 128) begin n_fail++; $display("FAIL mid_count got=%0d exp=128", strobe_cnt - s0); end
    for (int i = 64; i < 128; i++) begin
      got = (obs_q.size() > base + i) ? obs_q[base + i] : 'x;
      n_checks++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL mid_win%0d got=%h exp=%h", i - 64, got, exp_q[i]); end
    end
  endtask

  task automatic test_small_frame();
    int base5, s0;
    logic [W-1:0] got, expv;
    apply_reset();
    base5 = obs5_q.size(); s0 = strobe5_cnt;
    expv = exp_win(0, 5, 4, 4);
    for (int i = 0; i < 25; i++) drive5(1'b1, 12'(i));
    repeat (3) drive5(1'b0, 12'd0);
    n_checks++; if (strobe5_cnt - s0 !== 1) begin n_fail++; $display("FAIL small_count got=%0d exp=1", strobe5_cnt - s0); end
    got = (obs5_q.size() > base5) ? obs5_q[base5] : 'x;
    n_checks++; if (got !== expv) begin n_fail++; $display("FAIL small_win got=%h exp=%h", got, expv); end
    n_checks++; if (got[0*12 +: 12] !== 12'd0)   begin n_fail++; $display("FAIL small_tap0 got=%0d exp=0", got[0*12 +: 12]); end
    n_checks++; if (got[24*12 +: 12] !== 12'd24) begin n_fail++; $display("FAIL small_tap24 got=%0d exp=24", got[24*12 +: 12]); end
    n_checks++; if (dbg5.row !== 8'd0 || dbg5.col !== 8'd0) begin n_fail++; $display("FAIL small_wrap got=%0d/%0d exp=0/0", dbg5.row, dbg5.col); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_small_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
